// File: rtl/ibex_data_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : ibex_data_mem_bridge_if
// Description : LSU data-bus bundle (req/gnt/rvalid) between the load/store
//               unit and the data memory bridge.
//               master = LSU side, slave = bridge side.
// Signals     : data_req    LSU request
//               data_gnt    request accepted this cycle
//               data_addr   byte address, bits [1:0] always 00
//               data_we     1 = store
//               data_be     byte enables
//               data_wdata  store data, already lane-rotated
//               data_rvalid response valid, one per granted request
//               data_err    response error, qualified by data_rvalid
//               data_rdata  load data, qualified by data_rvalid
// Revision    : 1.0 - initial release
// ============================================================================
interface ibex_data_mem_bridge_if;
    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic        data_err;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_err, data_rdata
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_err, data_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ibex_data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ibex_data_mem_bridge
// Description : Bridges the LSU req/gnt/rvalid data bus onto a single-port
//               synchronous SRAM. Responses return in order after a fixed
//               Latency; accesses outside the SRAM window answer with err=1
//               and never touch the SRAM. Outstanding requests are bounded
//               by MaxOutstanding.
// Ports       : clk_i        clock
//               rst_i        synchronous active-high reset
//               lsu          LSU data bus (slave modport)
//               mem_req_o    SRAM access strobe
//               mem_we_o     SRAM write
//               mem_addr_o   SRAM word index
//               mem_be_o     SRAM byte write enables (0000 on loads)
//               mem_wdata_o  SRAM write data
//               mem_rdata_i  SRAM read data, valid the cycle after mem_req_o
//               mem_ready_i  SRAM can accept an access this cycle
//               busy_o       at least one request outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_data_mem_bridge #(
    parameter int          MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int          Latency        = 1,
    parameter int          MaxOutstanding = 2,
    localparam int         AW             = $clog2(MemWords)
) (
    input  wire                   clk_i,
    input  wire                   rst_i,
    ibex_data_mem_bridge_if.slave lsu,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [AW-1:0]         mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  wire  [31:0]           mem_rdata_i,
    input  wire                   mem_ready_i,
    output logic                  busy_o
);

    localparam logic [31:0] WinBytes = 32'(MemWords * 4);

    logic [31:0]        offset;
    logic               in_range;
    logic               gnt;
    logic               rvalid;
    logic               rsp_err;
    logic               rsp_we;
    logic [31:0]        rsp_data;

    logic [2:0]         pending_q;
    logic [2:0]         pending_d;
    logic [Latency-1:0] vld_q;
    logic [Latency-1:0] err_q;
    logic [Latency-1:0] we_q;

    // Unsigned subtraction: addresses below the base wrap to huge offsets and
    // therefore fall out of range without a second comparison.
    assign offset   = lsu.data_addr - BaseAddr;
    assign in_range = (offset < WinBytes);

    // A response leaving the pipe this cycle frees its slot immediately.
    assign rvalid = ~rst_i & vld_q[Latency-1];
    assign gnt    = ~rst_i & lsu.data_req & mem_ready_i &
                    ((pending_q < 3'(MaxOutstanding)) | rvalid);

    assign lsu.data_gnt = gnt;

    assign mem_req_o   = gnt & in_range;
    assign mem_we_o    = lsu.data_we;
    assign mem_addr_o  = offset[AW+1:2];
    assign mem_be_o    = lsu.data_we ? lsu.data_be : 4'b0000;
    assign mem_wdata_o = lsu.data_wdata;

    assign pending_d = pending_q + {2'b00, gnt} - {2'b00, rvalid};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            pending_q <= '0;
        end else begin
            vld_q[0] <= gnt;
            for (int k = 1; k < Latency; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            pending_q <= pending_d;
        end
    end

    // Attributes only matter where the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        err_q[0] <= ~in_range;
        we_q[0]  <= lsu.data_we;
        for (int k = 1; k < Latency; k++) begin
            err_q[k] <= err_q[k-1];
            we_q[k]  <= we_q[k-1];
        end
    end

    // SRAM data appears the cycle after grant, which is already the response
    // cycle when Latency is 1; otherwise it is captured and carried along.
    generate
        if (Latency == 1) begin : g_rdata_comb
            assign rsp_data = mem_rdata_i;
        end else begin : g_rdata_pipe
            logic [31:0] rdata_q [1:Latency-1];
            always_ff @(posedge clk_i) begin
                rdata_q[1] <= mem_rdata_i;
                for (int k = 2; k < Latency; k++) begin
                    rdata_q[k] <= rdata_q[k-1];
                end
            end
            assign rsp_data = rdata_q[Latency-1];
        end
    endgenerate

    assign rsp_err = err_q[Latency-1];
    assign rsp_we  = we_q[Latency-1];

    assign lsu.data_rvalid = rvalid;
    assign lsu.data_err    = rvalid & rsp_err;
    assign lsu.data_rdata  = (rvalid & ~rsp_err & ~rsp_we) ? rsp_data : 32'h0;

    assign busy_o = ~rst_i & (pending_q != 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_ibex_data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_data_mem_bridge
// Description : Bench for ibex_data_mem_bridge. Three bridge configurations
//               (Latency/MaxOutstanding = 1/1, 2/2, 4/2) receive the same
//               transaction list, each behind its own SRAM model, and are
//               compared every cycle against a transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_data_mem_bridge;

    localparam int          NCFG = 3;
    localparam int          MEMW = 1024;
    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam int          NTX  = 1024;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 4;
    endfunction

    function automatic int mo_of(input int g);
        return (g == 0) ? 1 : 2;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rdy;
    logic sram_clr;

    logic [NCFG-1:0] req_v, we_v;
    logic [31:0]     addr_a  [NCFG];
    logic [31:0]     wdata_a [NCFG];
    logic [3:0]      be_a    [NCFG];

    logic [NCFG-1:0] gnt_v, rvalid_v, err_v, mreq_v, mwe_v, busy_v;
    logic [31:0]     rdata_a  [NCFG];
    logic [31:0]     maddr_a  [NCFG];
    logic [31:0]     mwdata_a [NCFG];
    logic [3:0]      mbe_a    [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int LG = lat_of(g);
        localparam int MG = mo_of(g);

        ibex_data_mem_bridge_if bus ();

        logic        mreq, mwe, busy;
        logic [9:0]  maddr;
        logic [3:0]  mbe;
        logic [31:0] mwd, mrd;
        logic [31:0] sram [MEMW];

        ibex_data_mem_bridge #(
            .MemWords       (MEMW),
            .BaseAddr       (BASE),
            .Latency        (LG),
            .MaxOutstanding (MG)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .lsu         (bus),
            .mem_req_o   (mreq),
            .mem_we_o    (mwe),
            .mem_addr_o  (maddr),
            .mem_be_o    (mbe),
            .mem_wdata_o (mwd),
            .mem_rdata_i (mrd),
            .mem_ready_i (rdy),
            .busy_o      (busy)
        );

        assign bus.data_req   = req_v[g];
        assign bus.data_addr  = addr_a[g];
        assign bus.data_we    = we_v[g];
        assign bus.data_be    = be_a[g];
        assign bus.data_wdata = wdata_a[g];

        assign gnt_v[g]    = bus.data_gnt;
        assign rvalid_v[g] = bus.data_rvalid;
        assign err_v[g]    = bus.data_err;
        assign rdata_a[g]  = bus.data_rdata;
        assign mreq_v[g]   = mreq;
        assign mwe_v[g]    = mwe;
        assign maddr_a[g]  = {22'd0, maddr};
        assign mbe_a[g]    = mbe;
        assign mwdata_a[g] = mwd;
        assign busy_v[g]   = busy;

        // Single-port synchronous SRAM; read port shows garbage when idle.
        always @(posedge clk) begin
            if (sram_clr) begin
                for (int i = 0; i < MEMW; i++) sram[i] <= 32'h0;
                mrd <= 32'h0;
            end else if (mreq && !mwe) begin
                mrd <= sram[maddr];
            end else begin
                if (mreq) begin
                    for (int b = 0; b < 4; b++)
                        if (mbe[b]) sram[maddr][8*b +: 8] <= mwd[8*b +: 8];
                end
                mrd <= $urandom;
            end
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Transaction list shared by all configurations; each has its own head.
    int          ntx = 0;
    int          hd   [NCFG];
    logic [31:0] t_addr  [NTX];
    logic [31:0] t_wdata [NTX];
    logic        t_we    [NTX];
    logic [3:0]  t_be    [NTX];

    // Reference state: memory image, outstanding count, responses by due cycle.
    logic [31:0] mmem [NCFG][MEMW];
    int          pend [NCFG];
    bit          ev_t [NCFG][16];
    bit          er_t [NCFG][16];
    logic [31:0] dt_t [NCFG][16];

    task automatic chk(input string tag, input int g, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cfg%0d cyc%0d observed=%h expected=%h", tag, g, cyc, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd);
        if (ntx < NTX) begin
            t_addr[ntx]  = a;
            t_we[ntx]    = we;
            t_be[ntx]    = be;
            t_wdata[ntx] = wd;
            ntx++;
        end
    endtask

    task automatic cycle();
        int          slot, nslot, idx;
        logic [31:0] off, exd;
        bit          inr, eg, ev, eer;
        for (int g = 0; g < NCFG; g++) begin
            if (hd[g] < ntx) begin
                req_v[g]   = 1'b1;
                addr_a[g]  = t_addr[hd[g]];
                we_v[g]    = t_we[hd[g]];
                be_a[g]    = t_be[hd[g]];
                wdata_a[g] = t_wdata[hd[g]];
            end else begin
                req_v[g]   = 1'b0;
                addr_a[g]  = $urandom;
                we_v[g]    = 1'($urandom_range(0, 1));
                be_a[g]    = 4'($urandom);
                wdata_a[g] = $urandom;
            end
        end
        @(negedge clk);
        slot = cyc % 16;
        for (int g = 0; g < NCFG; g++) begin
            ev  = ev_t[g][slot] && !rst;
            eer = ev && er_t[g][slot];
            exd = ev ? dt_t[g][slot] : 32'h0;
            off = addr_a[g] - BASE;
            inr = (off < 32'(MEMW * 4));
            idx = inr ? int'(off >> 2) : 0;
            eg  = !rst && req_v[g] && rdy && ((pend[g] < mo_of(g)) || ev);

            chk("gnt", g, 32'(gnt_v[g]), 32'(eg));
            chk("mem_req", g, 32'(mreq_v[g]), 32'(eg && inr));
            if (eg && inr) begin
                chk("mem_addr", g, maddr_a[g], 32'(idx));
                chk("mem_we", g, 32'(mwe_v[g]), 32'(we_v[g]));
                chk("mem_be", g, 32'(mbe_a[g]), 32'(we_v[g] ? be_a[g] : 4'h0));
                if (we_v[g]) chk("mem_wdata", g, mwdata_a[g], wdata_a[g]);
            end
            chk("rvalid", g, 32'(rvalid_v[g]), 32'(ev));
            chk("err", g, 32'(err_v[g]), 32'(eer));
            chk("rdata", g, rdata_a[g], exd);
            chk("busy", g, 32'(busy_v[g]), 32'(!rst && pend[g] != 0));

            if (rst) begin
                for (int s = 0; s < 16; s++) ev_t[g][s] = 1'b0;
                pend[g] = 0;
            end else begin
                ev_t[g][slot] = 1'b0;
                if (eg) begin
                    nslot = (cyc + lat_of(g)) % 16;
                    ev_t[g][nslot] = 1'b1;
                    er_t[g][nslot] = !inr;
                    dt_t[g][nslot] = (inr && !we_v[g]) ? mmem[g][idx] : 32'h0;
                    if (inr && we_v[g]) begin
                        for (int b = 0; b < 4; b++)
                            if (be_a[g][b]) mmem[g][idx][8*b +: 8] = wdata_a[g][8*b +: 8];
                    end
                    hd[g]++;
                end
                pend[g] = pend[g] + int'(eg) - int'(ev);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int limit);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            cycle();
            n++;
            done = 1'b1;
            for (int g = 0; g < NCFG; g++)
                if (hd[g] < ntx || pend[g] != 0) done = 1'b0;
        end
        checks++;
        assert (done)
        else begin
            failures++;
            $error("FAIL drain cyc%0d observed=busy expected=idle within %0d cycles", cyc, limit);
        end
    endtask

    initial begin
        logic [31:0] a;
        rst      = 1'b1;
        rdy      = 1'b1;
        sram_clr = 1'b1;
        for (int g = 0; g < NCFG; g++) begin
            hd[g]   = 0;
            pend[g] = 0;
            for (int s = 0; s < 16; s++) ev_t[g][s] = 1'b0;
            for (int i = 0; i < MEMW; i++) mmem[g][i] = 32'h0;
        end

        // Reset: a request held during reset must wait until reset drops.
        push(BASE + 32'h40, 1'b0, 4'hF, 32'h0);
        cycle();
        cycle();
        sram_clr = 1'b0;
        rst      = 1'b0;
        drain(50);

        // Load/store round trip.
        push(32'h0010_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
        push(32'h0010_0010, 1'b0, 4'hF, 32'h0);
        drain(50);

        // Byte write and a store with no byte enables.
        push(BASE,          1'b1, 4'hF,    32'h1122_3344);
        push(BASE,          1'b1, 4'b0100, 32'h00AA_0000);
        push(BASE,          1'b0, 4'hF,    32'h0);
        push(BASE + 32'h4,  1'b1, 4'hF,    32'h5566_7788);
        push(BASE + 32'h4,  1'b1, 4'h0,    32'hFFFF_FFFF);
        push(BASE + 32'h4,  1'b0, 4'hF,    32'h0);
        drain(60);

        // Misaligned split: two consecutive words, request held.
        push(BASE,         1'b0, 4'hF, 32'h0);
        push(BASE + 32'h4, 1'b0, 4'hF, 32'h0);
        drain(50);

        // Out of range below, above, and wrapping; the store must have no effect.
        push(32'h000F_FFFC, 1'b0, 4'hF, 32'h0);
        push(32'h0010_1000, 1'b0, 4'hF, 32'h0);
        push(32'hFFFF_FFFC, 1'b1, 4'hF, 32'hCAFE_F00D);
        push(32'h0010_0FFC, 1'b0, 4'hF, 32'h0);
        drain(60);

        // Stall and outstanding limit, then SRAM not ready for 3 cycles.
        for (int i = 0; i < 6; i++) push(BASE + 32'(4 * i), 1'b0, 4'hF, 32'h0);
        cycle();
        cycle();
        rdy = 1'b0;
        cycle();
        cycle();
        cycle();
        rdy = 1'b1;
        drain(80);

        // Reset with requests in flight, then normal traffic again.
        push(BASE + 32'h8, 1'b0, 4'hF, 32'h0);
        push(BASE + 32'hC, 1'b0, 4'hF, 32'h0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        push(32'h0010_0010, 1'b0, 4'hF, 32'h0);
        drain(60);

        // Random traffic with SRAM stalls and one reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) < 2) begin
                if ($urandom_range(0, 9) == 0) begin
                    a = $urandom;
                    a[1:0] = 2'b00;
                end else begin
                    a = BASE + 32'(4 * $urandom_range(0, 15));
                end
                push(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            end
            rdy = ($urandom_range(0, 9) != 0);
            rst = (i == 200);
            cycle();
        end
        rst = 1'b0;
        rdy = 1'b1;
        drain(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ibex_data_mem_bridge.md
# ibex_data_mem_bridge

Data-side memory bridge sitting directly downstream of the load/store unit. It accepts the LSU's req/gnt/rvalid data bus, with word-aligned addresses and byte enables, and drives a single-port synchronous SRAM. It returns in-order responses after a configurable fixed latency and flags out-of-range accesses as bus errors. It also bounds the number of outstanding transactions, so misaligned split accesses from the LSU (two back-to-back requests) are handled without loss.

## Interface
- MemWords, 1024: SRAM depth in 32-bit words; power of two; AW = clog2(MemWords)
- BaseAddr, 32'h0010_0000: byte base address of SRAM window; aligned to MemWords*4
- Latency, 1: cycles from grant to rvalid; legal 1..4
- MaxOutstanding, 2: max granted-but-unanswered requests; legal 1..4

- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- data_req_i  in  1  LSU request
- data_gnt_o  out  1  request accepted this cycle
- data_addr_i  in  32  byte address, bits [1:0] always 00
- data_we_i  in  1  1 = store
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  store data, already lane-rotated by LSU
- data_rvalid_o  out  1  response valid, one per granted request
- data_err_o  out  1  response error, qualified by data_rvalid_o
- data_rdata_o  out  32  load data, qualified by data_rvalid_o
- mem_req_o  out  1  SRAM access strobe
- mem_we_o  out  1  SRAM write
- mem_addr_o  out  AW  SRAM word index
- mem_be_o  out  4  SRAM byte write enables
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data, valid cycle after mem_req_o
- mem_ready_i  in  1  SRAM can accept an access this cycle
- busy_o  out  1  pending count != 0

## Operation
- In range: data_addr_i - BaseAddr < MemWords*4, unsigned 32-bit subtraction, wrap counts as out of range.
- Grant: data_gnt_o = data_req_i & mem_ready_i & (pending < MaxOutstanding | data_rvalid_o). Combinational; a response retiring in the same cycle frees a slot.
- On grant, in range: mem_req_o=1 same cycle; mem_addr_o = (data_addr_i - BaseAddr)[AW+1:2]; mem_we_o/mem_be_o/mem_wdata_o pass through. mem_be_o is forced to 0000 when data_we_i=0.
- On grant, out of range: mem_req_o=0; the response carries err=1. No SRAM side effect.
- Store with data_be_i=0000: granted, mem_req_o=1, mem_be_o=0000, err=0.
- Response pipeline: Latency stages carrying {valid, err, we}. Read data is captured from mem_rdata_i in the cycle after grant and travels with the entry.
- data_rdata_o = captured SRAM data for in-range loads; 0 for stores and errors.
- Pending counter, 0..MaxOutstanding: +1 on grant, −1 on data_rvalid_o; both in one cycle leave it unchanged.
- Responses are strictly in grant order. data_rvalid_o has no backpressure; the LSU always accepts it.
- When no grant occurs, mem_* data outputs are don't-care with mem_req_o=0.

## Timing
- Grant at cycle T gives data_rvalid_o at exactly T+Latency.
- Latency=1: data_rdata_o may be combinational from mem_rdata_i at T+1. Latency>1: registered.
- Back-to-back grants at T and T+1 give rvalid at T+L and T+L+1.
- Throughput is one per cycle when MaxOutstanding ≥ Latency; otherwise grants stall until a slot frees.
- mem_ready_i=0 blocks grants only; in-flight responses still retire on schedule.
- Reset (rst_i=1 at a clock edge): pipeline valids cleared, pending=0. In-flight responses are dropped, never emitted.
- Output values during and after reset: data_rvalid_o=0, data_err_o=0, data_rdata_o=0, busy_o=0.
- During reset, data_gnt_o and mem_req_o are forced 0, regardless of data_req_i.
- Requests presented in the reset cycle are not granted.

## Test plan
- Load/store round trip: store 32'hDEAD_BEEF, be=1111 to 32'h0010_0010, then load the same address. Load rvalid arrives Latency cycles after its grant with rdata=32'hDEAD_BEEF, err=0; mem_addr_o=4.
- Byte write: prefill word 0 with 32'h1122_3344, store be=0100 with wdata=32'h00AA_0000, then load. Response is 32'h11AA_3344.
- Misaligned split: Latency=2, MaxOutstanding=2, requests held high for two consecutive words at 32'h0010_0000/04. Grants come in consecutive cycles; rvalid arrives at T+2 and T+3, in order.
- Out of range: loads to 32'h000F_FFFC and 32'h0010_1000 (MemWords=1024). Each is granted with mem_req_o=0 and gets rvalid with err=1, rdata=0.
- Stall and limit: Latency=4, MaxOutstanding=2, continuous requests. Grants occur at T and T+1, none until T+4 (the first rvalid frees a slot in the same cycle). mem_ready_i=0 for 3 cycles gives no grants while responses still retire.
- Reset mid-flight: assert rst_i one cycle after two grants. No rvalid is ever emitted for them; busy_o=0 afterwards; a new request after reset completes normally.
